// File: rtl/fwd_hazard_unit.sv
// ---------------------------------------------------------------------------
// fwd_hazard_unit
//
// Forwarding and load-use hazard unit for the lc3b pipeline.
//
// The unit keeps a small shift-register scoreboard of in-flight destination
// registers. It advances in lockstep with the pipeline: entry 0 holds the
// instruction now in EX, and entry NUM_STAGES-1 is the oldest.
//
// For each source operand of the decode instruction, the youngest matching
// writer is chosen. That choice is registered as a forward-mux select at the
// ID/EX boundary.
//
// A load whose data is not yet forwardable (matched at an index below
// LOAD_STAGE) raises a stall and injects a bubble.
//
// Optional build macro: FWD_PERF_CNT_EN
//   When defined, the unit adds two saturating 16-bit performance counters,
//   perf_stall_cnt and perf_fwd_cnt.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   id_valid       decode holds a real instruction
//   id_load_reg    decode instruction writes a register
//   id_is_load     decode instruction is a memory load
//   id_dr          decode destination register
//   id_sr          decode source registers, src s at [s*REG_W +: REG_W]
//   id_sr_used     per-source "actually read" flags
//   id_flush       squash the decode instruction
//   mem_stall      whole pipeline frozen
//   stall          hold PC and IF/ID, bubble into EX (combinational)
//   fwd_sel        registered per-source select: 0 = regfile, k+1 = entry k
//   sb_busy        scoreboard valid bits (debug)
//   perf_stall_cnt / perf_fwd_cnt  (FWD_PERF_CNT_EN only)
// ---------------------------------------------------------------------------
module fwd_hazard_unit #(
    parameter  int REG_W      = 3,
    parameter  int NUM_SRC    = 2,
    parameter  int NUM_STAGES = 2,
    parameter  int LOAD_STAGE = 1,
    localparam int SEL_W      = $clog2(NUM_STAGES + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     id_valid,
    input  logic                     id_load_reg,
    input  logic                     id_is_load,
    input  logic [REG_W-1:0]         id_dr,
    input  logic [NUM_SRC*REG_W-1:0] id_sr,
    input  logic [NUM_SRC-1:0]       id_sr_used,
    input  logic                     id_flush,
    input  logic                     mem_stall,
    output logic                     stall,
    output logic [NUM_SRC*SEL_W-1:0] fwd_sel,
    output logic [NUM_STAGES-1:0]    sb_busy
`ifdef FWD_PERF_CNT_EN
    ,
    output logic [15:0]              perf_stall_cnt,
    output logic [15:0]              perf_fwd_cnt
`endif
);

    logic [NUM_STAGES-1:0]    sb_valid_r;
    logic [NUM_STAGES-1:0]    sb_load_r;
    logic [REG_W-1:0]         sb_dr_r [NUM_STAGES];
    logic [NUM_SRC*SEL_W-1:0] fwd_sel_r;

    logic [NUM_SRC*SEL_W-1:0] sel_s;
    logic [NUM_SRC*SEL_W-1:0] sel_next_s;
    logic [NUM_SRC-1:0]       win_load_s;
    logic                     hazard_s;
    logic                     ent0_valid_s;

    // Per-source youngest-writer search and load-use hazard detection.
    always_comb begin
        sel_s      = '0;
        win_load_s = '0;
        // Scan oldest to youngest, so the lowest matching index is written
        // last and therefore wins.
        for (int s = 0; s < NUM_SRC; s++) begin
            for (int k = NUM_STAGES - 1; k >= 0; k--) begin
                sel_s[s*SEL_W +: SEL_W] =
                    (id_sr_used[s] && sb_valid_r[k] && (sb_dr_r[k] == id_sr[s*REG_W +: REG_W]))
                    ? SEL_W'(k + 1) : sel_s[s*SEL_W +: SEL_W];
                win_load_s[s] =
                    (id_sr_used[s] && sb_valid_r[k] && (sb_dr_r[k] == id_sr[s*REG_W +: REG_W]))
                    ? (sb_load_r[k] && (k < LOAD_STAGE)) : win_load_s[s];
            end
        end
        hazard_s = id_valid && !id_flush && (|win_load_s);
    end

    // Decide what enters entry 0 and which selects are registered on the next advance.
    always_comb begin
        ent0_valid_s = 1'b0;
        sel_next_s   = '0;
        if (hazard_s || id_flush || !id_valid) begin
            ent0_valid_s = 1'b0;
            sel_next_s   = '0;
        end else begin
            ent0_valid_s = id_load_reg;
            sel_next_s   = sel_s;
        end
    end

    // Scoreboard shift and registered forward selects; frozen while memory stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_valid_r <= '0;
            sb_load_r  <= '0;
            fwd_sel_r  <= '0;
            for (int k = 0; k < NUM_STAGES; k++) begin
                sb_dr_r[k] <= '0;
            end
        end else if (!mem_stall) begin
            for (int k = NUM_STAGES - 1; k >= 1; k--) begin
                sb_valid_r[k] <= sb_valid_r[k-1];
                sb_load_r[k]  <= sb_load_r[k-1];
                sb_dr_r[k]    <= sb_dr_r[k-1];
            end
            sb_valid_r[0] <= ent0_valid_s;
            sb_load_r[0]  <= ent0_valid_s && id_is_load;
            sb_dr_r[0]    <= id_dr;
            fwd_sel_r     <= sel_next_s;
        end else begin
            // Memory stall: everything holds.
            fwd_sel_r <= fwd_sel_r;
        end
    end

    assign stall   = hazard_s && !mem_stall;
    assign fwd_sel = fwd_sel_r;
    assign sb_busy = sb_valid_r;

`ifdef FWD_PERF_CNT_EN
    logic [15:0] perf_stall_cnt_r;
    logic [15:0] perf_fwd_cnt_r;

    // Saturating counters for stall cycles and advances that register a forward.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cnt_r <= 16'd0;
            perf_fwd_cnt_r   <= 16'd0;
        end else begin
            if (stall && (perf_stall_cnt_r != 16'hFFFF)) begin
                perf_stall_cnt_r <= perf_stall_cnt_r + 16'd1;
            end else begin
                perf_stall_cnt_r <= perf_stall_cnt_r;
            end
            if (!mem_stall && (|sel_next_s) && (perf_fwd_cnt_r != 16'hFFFF)) begin
                perf_fwd_cnt_r <= perf_fwd_cnt_r + 16'd1;
            end else begin
                perf_fwd_cnt_r <= perf_fwd_cnt_r;
            end
        end
    end

    assign perf_stall_cnt = perf_stall_cnt_r;
    assign perf_fwd_cnt   = perf_fwd_cnt_r;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// ---------------------------------------------------------------------------
// tb_fwd_hazard_unit
//
// Directed bench for fwd_hazard_unit with default parameters.
//
// A behavioural model keeps a list of in-flight writers and searches it for
// the youngest producer of each source. A compare process checks stall,
// fwd_sel and sb_busy against that model on every falling edge. Literal
// expectations at key points pin the model itself.
// ---------------------------------------------------------------------------
module tb_fwd_hazard_unit;

    localparam int NUM_STAGES = 2;
    localparam int LOAD_STAGE = 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid, id_load_reg, id_is_load, id_flush, mem_stall;
    logic [2:0] id_dr;
    logic [5:0] id_sr;
    logic [1:0] id_sr_used;
    logic       stall;
    logic [3:0] fwd_sel;
    logic [1:0] sb_busy;
`ifdef FWD_PERF_CNT_EN
    logic [15:0] perf_stall_cnt, perf_fwd_cnt;
    logic [15:0] fwd_cnt_before;
`endif

    fwd_hazard_unit dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_load_reg(id_load_reg),
        .id_is_load(id_is_load), .id_dr(id_dr), .id_sr(id_sr), .id_sr_used(id_sr_used),
        .id_flush(id_flush), .mem_stall(mem_stall), .stall(stall), .fwd_sel(fwd_sel),
        .sb_busy(sb_busy)
`ifdef FWD_PERF_CNT_EN
        , .perf_stall_cnt(perf_stall_cnt), .perf_fwd_cnt(perf_fwd_cnt)
`endif
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    logic chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic       v;
        logic [2:0] dr;
        logic       ld;
    } ent_t;

    ent_t       m_ent [NUM_STAGES] = '{default: '0};
    logic [3:0] m_sel = 4'd0;

    // Index of the youngest in-flight writer of r, or -1 when there is none.
    function automatic int youngest(input logic [2:0] r);
        for (int k = 0; k < NUM_STAGES; k++)
            if (m_ent[k].v && m_ent[k].dr == r) return k;
        return -1;
    endfunction

    function automatic logic [3:0] model_sel();
        logic [3:0] r;
        int y;
        r = 4'd0;
        for (int s = 0; s < 2; s++) begin
            y = youngest(id_sr[s*3 +: 3]);
            if (id_sr_used[s] && y >= 0) r[s*2 +: 2] = 2'(y + 1);
        end
        return r;
    endfunction

    function automatic logic model_hazard();
        int y;
        logic h;
        h = 1'b0;
        for (int s = 0; s < 2; s++) begin
            y = youngest(id_sr[s*3 +: 3]);
            if (id_sr_used[s] && y >= 0 && m_ent[y].ld && y < LOAD_STAGE) h = 1'b1;
        end
        return id_valid && !id_flush && h;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_STAGES; k++) m_ent[k] <= '0;
            m_sel <= 4'd0;
        end else if (!mem_stall) begin
            for (int k = 1; k < NUM_STAGES; k++) m_ent[k] <= m_ent[k-1];
            if (model_hazard() || id_flush || !id_valid) begin
                m_ent[0] <= '0;
                m_sel    <= 4'd0;
            end else begin
                m_ent[0] <= '{v: id_load_reg, dr: id_dr, ld: id_is_load & id_load_reg};
                m_sel    <= model_sel();
            end
        end
    end

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            logic [1:0] busy;
            for (int k = 0; k < NUM_STAGES; k++) busy[k] = m_ent[k].v;
            check("model_stall", {31'd0, stall}, {31'd0, model_hazard() && !mem_stall});
            check("model_fwd_sel", {28'd0, fwd_sel}, {28'd0, m_sel});
            check("model_sb_busy", {30'd0, sb_busy}, {30'd0, busy});
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_in(input logic v, input logic lr, input logic il, input logic [2:0] dr,
                          input logic [2:0] s0, input logic [2:0] s1, input logic [1:0] used,
                          input logic fl, input logic ms);
        id_valid = v; id_load_reg = lr; id_is_load = il; id_dr = dr;
        id_sr = {s1, s0}; id_sr_used = used; id_flush = fl; mem_stall = ms;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b1;
        set_in(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 2'b00, 1'b0, 1'b0);
        rst_n = 1'b0;
        chk_en = 1'b1;
        tick(); tick();
        #3 rst_n = 1'b1;
        tick();
        check("reset_busy", {30'd0, sb_busy}, 32'd0);
        check("reset_sel", {28'd0, fwd_sel}, 32'd0);
        check("reset_stall", {31'd0, stall}, 32'd0);

        // ADD R1; ADD R2,R1,R1; ADD R3,R1,R0
        set_in(1'b1, 1'b1, 1'b0, 3'd1, 3'd0, 3'd0, 2'b11, 1'b0, 1'b0); tick();
        check("add_r1_busy", {30'd0, sb_busy}, 32'h1);
        set_in(1'b1, 1'b1, 1'b0, 3'd2, 3'd1, 3'd1, 2'b11, 1'b0, 1'b0); tick();
        check("ex_mem_fwd", {28'd0, fwd_sel}, 32'h5);
        set_in(1'b1, 1'b1, 1'b0, 3'd3, 3'd1, 3'd0, 2'b11, 1'b0, 1'b0); tick();
        check("mem_wb_fwd", {28'd0, fwd_sel}, 32'h2);

        // Two writers of R4: the youngest wins.
        set_in(1'b1, 1'b1, 1'b0, 3'd4, 3'd0, 3'd0, 2'b00, 1'b0, 1'b0); tick();
        set_in(1'b1, 1'b1, 1'b0, 3'd4, 3'd0, 3'd0, 2'b00, 1'b0, 1'b0); tick();
        set_in(1'b1, 1'b1, 1'b0, 3'd5, 3'd4, 3'd4, 2'b11, 1'b0, 1'b0); tick();
        check("youngest_wins", {28'd0, fwd_sel}, 32'h5);

        // LDR R5; ADD R6,R5,R5 -> one bubble, then sel=2 on both sources.
        set_in(1'b1, 1'b1, 1'b1, 3'd5, 3'd0, 3'd0, 2'b00, 1'b0, 1'b0); tick();
        set_in(1'b1, 1'b1, 1'b0, 3'd6, 3'd5, 3'd5, 2'b11, 1'b0, 1'b0);
        check("lu_stall", {31'd0, stall}, 32'h1);
        tick();
        check("lu_bubble_sel", {28'd0, fwd_sel}, 32'h0);
        check("lu_bubble_busy", {30'd0, sb_busy}, 32'h2);
        check("lu_stall_clear", {31'd0, stall}, 32'h0);
        tick();
        check("lu_after_sel", {28'd0, fwd_sel}, 32'hA);

        // LDR R5,[R6]; consumer held by mem_stall for 3 cycles.
        set_in(1'b1, 1'b1, 1'b1, 3'd5, 3'd6, 3'd0, 2'b01, 1'b0, 1'b0); tick();
        check("ldr_fwd_sel", {28'd0, fwd_sel}, 32'h1);
        set_in(1'b1, 1'b1, 1'b0, 3'd6, 3'd5, 3'd5, 2'b11, 1'b0, 1'b1);
        check("ms_no_stall", {31'd0, stall}, 32'h0);
        tick(); tick(); tick();
        check("ms_frozen_sel", {28'd0, fwd_sel}, 32'h1);
        check("ms_frozen_busy", {30'd0, sb_busy}, 32'h3);
        set_in(1'b1, 1'b1, 1'b0, 3'd6, 3'd5, 3'd5, 2'b11, 1'b0, 1'b0);
        check("ms_release_stall", {31'd0, stall}, 32'h1);
        tick();
        check("ms_bubble_sel", {28'd0, fwd_sel}, 32'h0);
        tick();
        check("ms_after_sel", {28'd0, fwd_sel}, 32'hA);

        // Flush in the same cycle as a load-use hazard.
        set_in(1'b1, 1'b1, 1'b1, 3'd5, 3'd0, 3'd0, 2'b00, 1'b0, 1'b0); tick();
        set_in(1'b1, 1'b1, 1'b0, 3'd6, 3'd5, 3'd5, 2'b11, 1'b1, 1'b0);
        check("flush_no_stall", {31'd0, stall}, 32'h0);
        tick();
        check("flush_sel", {28'd0, fwd_sel}, 32'h0);
        check("flush_busy", {30'd0, sb_busy}, 32'h2);
        set_in(1'b1, 1'b1, 1'b0, 3'd7, 3'd5, 3'd0, 2'b01, 1'b0, 1'b0); tick();
        check("pre_reset_sel", {28'd0, fwd_sel}, 32'h2);
        check("pre_reset_busy", {30'd0, sb_busy}, 32'h1);

        // Mid-operation asynchronous reset.
        #1 rst_n = 1'b0;
        #1;
        check("midrst_busy", {30'd0, sb_busy}, 32'h0);
        check("midrst_sel", {28'd0, fwd_sel}, 32'h0);
        set_in(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 2'b00, 1'b0, 1'b0);
        tick(); tick();
        rst_n = 1'b1;
        set_in(1'b1, 1'b1, 1'b0, 3'd1, 3'd7, 3'd0, 2'b01, 1'b0, 1'b0);
        check("post_rst_stall", {31'd0, stall}, 32'h0);
        tick();
        check("post_rst_sel", {28'd0, fwd_sel}, 32'h0);

        // R0 is an ordinary, matchable destination.
        set_in(1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 3'd0, 2'b00, 1'b0, 1'b0); tick();
        set_in(1'b1, 1'b1, 1'b0, 3'd1, 3'd0, 3'd0, 2'b01, 1'b0, 1'b0);
`ifdef FWD_PERF_CNT_EN
        fwd_cnt_before = perf_fwd_cnt;
`endif
        tick();
        check("r0_fwd_sel", {28'd0, fwd_sel}, 32'h1);
`ifdef FWD_PERF_CNT_EN
        check("perf_fwd_inc", {16'd0, perf_fwd_cnt}, {16'd0, fwd_cnt_before + 16'd1});
`endif

        set_in(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 2'b00, 1'b0, 1'b0);
        tick(); tick();
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
